// File: rtl/pll_phase_ctrl_pkg.sv
// Shared definitions for the PLL dynamic phase-shift initiator.
//
// Contents:
//   state_e    - sequencer states (idle, setup, pulse, wait for phase_done low/high, finish)
//   PULSE_LEN  - number of scanclk cycles phase_en is held high per step
//   cntsel_e   - PLL counter-select encodings for outclk_0..outclk_2
package pll_phase_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StSetup,
      StPulse,
      StWaitLo,
      StWaitHi,
      StFin
   } state_e;

   localparam int unsigned PULSE_LEN = 2;

   typedef enum logic [4:0] {
      CntselOutclk0 = 5'd0,
      CntselOutclk1 = 5'd1,
      CntselOutclk2 = 5'd2
   } cntsel_e;

endpackage

// File: rtl/pll_phase_ctrl_if.sv
// Request/status bus between the clock-tuning logic and pll_phase_ctrl.
//
// Signals:
//   req      - request strobe, accepted when the controller is idle and the PLL is locked
//   target   - signed desired phase position, sampled on an accepted req
//   busy     - sequence in progress
//   done     - one-cycle completion (or abort) pulse
//   err      - sticky phase_done timeout flag
//   position - signed current phase position
// Modports: master = requester, slave = pll_phase_ctrl.
interface pll_phase_ctrl_if #(
   parameter int unsigned POS_W = 8
) ();

   logic                    req;
   logic signed [POS_W-1:0] target;
   logic                    busy;
   logic                    done;
   logic                    err;
   logic signed [POS_W-1:0] position;

   modport master (
      output req,
      output target,
      input  busy,
      input  done,
      input  err,
      input  position
   );

   modport slave (
      input  req,
      input  target,
      output busy,
      output done,
      output err,
      output position
   );

endinterface

// File: rtl/pll_phase_ctrl_sync2.sv
// Two-flop synchroniser for asynchronous single-bit inputs.
//
// Ports:
//   clk - destination clock
//   rst - asynchronous active-high reset, clears both flops to 0
//   d   - asynchronous input
//   q   - synchronised output (two clk cycles of latency)
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= 1'b0;
         q      <= 1'b0;
      end else begin
         meta_q <= d;
         q      <= meta_q;
      end
   end

endmodule

// File: rtl/pll_phase_ctrl.sv
// PLL dynamic phase-shift initiator.
//
// Accepts a signed target phase position (VCO steps relative to the power-up phase) and walks
// the PLL there one step at a time via phase_en/updn/cntsel, handshaking on phase_done. The
// current position is tracked so that later requests only issue the difference. Loss of lock
// aborts any sequence and zeroes the position, since the PLL returns to its configured phase.
//
// Ports:
//   scanclk    - sole clock, also fed to the PLL scanclk
//   rst        - asynchronous active-high reset
//   locked     - PLL lock (asynchronous, synchronised here)
//   ctl        - request/status bus (req, target, busy, done, err, position)
//   phase_en   - to PLL, high for PULSE_LEN cycles per step
//   updn       - to PLL, 1 = step up (position + 1)
//   cntsel     - to PLL, counter select, CNTSEL_VAL during a sequence, 0 when idle
//   phase_done - from PLL (asynchronous, synchronised here)
//
// Build option: define PHASE_CTRL_TIMEOUT_EN to bound each phase_done wait to PD_TIMEOUT
// cycles; on expiry err is set and the sequence finishes without moving position. Without
// it the waits are unbounded and err is constant 0.
module pll_phase_ctrl
   import pll_phase_pkg::*;
#(
   parameter int unsigned POS_W      = 8,
   parameter logic [4:0]  CNTSEL_VAL = CntselOutclk1,
   parameter int unsigned PD_TIMEOUT = 255
) (
   input  logic             scanclk,
   input  logic             rst,
   input  logic             locked,
   pll_phase_ctrl_if.slave  ctl,
   output logic             phase_en,
   output logic             updn,
   output logic [4:0]       cntsel,
   input  logic             phase_done
);

   localparam int unsigned PulseCntW = (PULSE_LEN > 1) ? $clog2(PULSE_LEN) : 1;

   logic pd_s;
   logic locked_s;

   state_e                  state_q;
   logic signed [POS_W-1:0] tgt_q;
   logic signed [POS_W-1:0] pos_q;
   logic signed [POS_W-1:0] pos_step;
   logic [PulseCntW-1:0]    pulse_cnt_q;
   logic                    phase_en_q;
   logic                    updn_q;
   logic [4:0]              cntsel_q;
   logic                    busy_q;
   logic                    done_q;
   logic                    active;

`ifdef PHASE_CTRL_TIMEOUT_EN
   localparam int unsigned TmoW = $clog2(PD_TIMEOUT + 1);

   logic [TmoW-1:0] tmo_cnt_q;
   logic            tmo_hit;
   logic            err_q;

   // Fires on the PD_TIMEOUT-th cycle spent in a wait state.
   assign tmo_hit = (tmo_cnt_q == TmoW'(PD_TIMEOUT - 1));
`else
   // PD_TIMEOUT only matters when the timeout is built in.
   if (PD_TIMEOUT == 0) begin : g_tmo_unused
   end
`endif

   sync2 u_sync_pd (
      .clk (scanclk),
      .rst (rst),
      .d   (phase_done),
      .q   (pd_s)
   );

   sync2 u_sync_lock (
      .clk (scanclk),
      .rst (rst),
      .d   (locked),
      .q   (locked_s)
   );

   // Position after the step currently in flight completes.
   assign pos_step = updn_q ? (pos_q + POS_W'(1)) : (pos_q - POS_W'(1));

   // States in which a lock loss must abort the sequence.
   assign active = (state_q == StSetup) || (state_q == StPulse) ||
                   (state_q == StWaitLo) || (state_q == StWaitHi);

   always_ff @(posedge scanclk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         tgt_q       <= '0;
         pos_q       <= '0;
         pulse_cnt_q <= '0;
         phase_en_q  <= 1'b0;
         updn_q      <= 1'b0;
         cntsel_q    <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef PHASE_CTRL_TIMEOUT_EN
         tmo_cnt_q   <= '0;
         err_q       <= 1'b0;
`endif
      end else begin
         done_q <= 1'b0;

         // The PLL reverts to its configured phase on relock.
         if (!locked_s) begin
            pos_q <= '0;
         end

         if (!locked_s && active) begin
            phase_en_q <= 1'b0;
            state_q    <= StFin;
         end else begin
            unique case (state_q)
               StIdle: begin
                  if (ctl.req && !busy_q && locked_s) begin
                     tgt_q  <= ctl.target;
                     busy_q <= 1'b1;
`ifdef PHASE_CTRL_TIMEOUT_EN
                     err_q  <= 1'b0;
`endif
                     if (ctl.target == pos_q) begin
                        state_q <= StFin;
                     end else begin
                        updn_q   <= (ctl.target > pos_q);
                        cntsel_q <= CNTSEL_VAL;
                        state_q  <= StSetup;
                     end
                  end
               end

               StSetup: begin
                  phase_en_q  <= 1'b1;
                  pulse_cnt_q <= '0;
                  state_q     <= StPulse;
               end

               StPulse: begin
                  if (pulse_cnt_q == PulseCntW'(PULSE_LEN - 1)) begin
                     phase_en_q <= 1'b0;
                     state_q    <= StWaitLo;
`ifdef PHASE_CTRL_TIMEOUT_EN
                     tmo_cnt_q  <= '0;
`endif
                  end else begin
                     pulse_cnt_q <= pulse_cnt_q + PulseCntW'(1);
                  end
               end

               StWaitLo: begin
                  if (!pd_s) begin
                     state_q   <= StWaitHi;
`ifdef PHASE_CTRL_TIMEOUT_EN
                     tmo_cnt_q <= '0;
                  end else if (tmo_hit) begin
                     err_q     <= 1'b1;
                     state_q   <= StFin;
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
`endif
                  end
               end

               StWaitHi: begin
                  if (pd_s) begin
                     pos_q <= pos_step;
                     // updn already points toward tgt_q, so it is simply held.
                     state_q <= (pos_step == tgt_q) ? StFin : StSetup;
`ifdef PHASE_CTRL_TIMEOUT_EN
                  end else if (tmo_hit) begin
                     err_q     <= 1'b1;
                     state_q   <= StFin;
                  end else begin
                     tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
`endif
                  end
               end

               StFin: begin
                  done_q     <= 1'b1;
                  busy_q     <= 1'b0;
                  phase_en_q <= 1'b0;
                  updn_q     <= 1'b0;
                  cntsel_q   <= '0;
                  state_q    <= StIdle;
               end

               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign phase_en     = phase_en_q;
   assign updn         = updn_q;
   assign cntsel       = cntsel_q;
   assign ctl.busy     = busy_q;
   assign ctl.done     = done_q;
   assign ctl.position = pos_q;
`ifdef PHASE_CTRL_TIMEOUT_EN
   assign ctl.err      = err_q;
`else
   assign ctl.err      = 1'b0;
`endif

endmodule
